uart_fifo_core: RTL and testbench

//  Parametrised full-duplex UART with runtime baud divisor, 5-8 data bits, optional parity,
//  1/2 stop bits, TX/RX FIFOs and sticky error flags. Sits between the CPU MMIO bus and
//  the board serial pins.

---
 rtl/uart_fifo_core.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// Full-duplex UART core: runtime baud divisor, 5..8 data bits, optional parity,
// 1/2 stop bits, TX/RX first-word fall-through FIFOs and sticky error flags.

// Synchronous FIFO with power-of-2 depth and an extra wrap bit on each pointer.
// The parent decides acceptance; push and pop arrive already qualified.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer advance on qualified push/pop
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    // NOTE: the array has no reset; occupancy comes from the pointers alone.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        clk_en,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  data_len,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        two_stop,
    input  logic                        rx_serial,
    output logic                        tx_serial,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_wr,
    output logic                        tx_full,
    output logic                        tx_busy,
    output logic [DATA_BITS-1:0]        rx_data,
    input  logic                        rx_rd,
    output logic                        rx_empty,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic [2:0]                  err_flags,
    input  logic                        err_clr
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    // Runtime data width: data_len+5, capped at DATA_BITS
    function automatic logic [3:0] frame_bits(input logic [1:0] len);
        logic [3:0] n;
        n = {2'b00, len} + 4'd5;
        if (n > 4'(DATA_BITS)) n = 4'(DATA_BITS);
        return n;
    endfunction

    function automatic logic [DATA_BITS-1:0] len_mask(input logic [3:0] n);
        logic [DATA_BITS-1:0] m;
        for (int i = 0; i < DATA_BITS; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_next;
    logic [DIV_W-1:0]     tx_div, tx_cnt;
    logic [3:0]           tx_nbits, tx_bit_idx;
    logic                 tx_par_en, tx_two_stop, tx_par_bit, tx_stop_idx;
    logic [DATA_BITS-1:0] tx_shift, tx_head;
    logic [LW-1:0]        tx_level;
    logic                 tx_fifo_empty, tx_bit_end, tx_pop, tx_push, tx_serial_d;

    assign tx_push       = tx_wr && !tx_full;
    assign tx_fifo_empty = (tx_level == '0);
    assign tx_bit_end    = clk_en && (tx_cnt == tx_div - 1'b1);
    assign tx_busy       = (tx_state != TX_IDLE) || !tx_fifo_empty;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_data),
        .rdata (tx_head),
        .full  (tx_full),
        .level (tx_level)
    );

    // TX state register
    always_ff @(posedge CLK) begin
        if (RST) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // TX next state; stop chains straight into the next start when data waits
    always_comb begin
        // NOTE: default first so no path leaves tx_next unassigned (no latch).
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:   if (clk_en && !tx_fifo_empty) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit_idx == tx_nbits - 1'b1)
                           tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && (!tx_two_stop || tx_stop_idx))
                           tx_next = tx_fifo_empty ? TX_IDLE : TX_START;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: FIFO pop on start entry and the next value of the line register
    always_comb begin
        tx_pop      = (tx_next == TX_START) && (tx_state != TX_START);
        tx_serial_d = tx_serial;
        unique case (tx_next)
            TX_IDLE, TX_STOP: tx_serial_d = 1'b1;
            TX_START:         tx_serial_d = 1'b0;
            TX_DATA: begin
                if (tx_state == TX_START) tx_serial_d = tx_shift[0];
                else if (tx_bit_end)      tx_serial_d = tx_shift[1];
            end
            TX_PARITY:        tx_serial_d = tx_par_bit;
            default:          tx_serial_d = 1'b1;
        endcase
    end

    // TX datapath: per-frame config latch, bit timer, shifter, line register
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_serial   <= 1'b1;
            tx_div      <= '0;
            tx_cnt      <= '0;
            tx_nbits    <= '0;
            tx_bit_idx  <= '0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
        end else begin
            tx_serial <= tx_serial_d;
            if (tx_pop) begin
                tx_div      <= baud_div;
                tx_nbits    <= frame_bits(data_len);
                tx_par_en   <= parity_en;
                tx_two_stop <= two_stop;
                tx_par_bit  <= (^(tx_head & len_mask(frame_bits(data_len)))) ^ parity_odd;
                tx_shift    <= tx_head;
                tx_cnt      <= '0;
                tx_bit_idx  <= '0;
                tx_stop_idx <= 1'b0;
            end else if (clk_en && tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_idx <= tx_bit_idx + 1'b1;
                    end
                    if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_next;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                 rx_s, rx_prev;
    logic [DIV_W-1:0]     rx_div, rx_cnt;
    logic [3:0]           rx_nbits, rx_bit_idx;
    logic                 rx_par_en, rx_par_odd, rx_par_acc;
    logic [DATA_BITS-1:0] rx_shift, rx_word;
    logic                 rx_sample, rx_push, rx_push_ok, rx_pop, rx_full;
    logic [2:0]           err_set;

    assign rx_s      = rx_sync[SYNC_STAGES-1];
    assign rx_empty  = (rx_level == '0);
    assign rx_pop    = rx_rd && !rx_empty;
    assign rx_sample = clk_en && ((rx_state == RX_START) ? (rx_cnt == (rx_div >> 1) - 1'b1)
                                                         : (rx_cnt == rx_div - 1'b1));

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (rx_push_ok),
        .pop   (rx_pop),
        .wdata (rx_word),
        .rdata (rx_data),
        .full  (rx_full),
        .level (rx_level)
    );

    // Input synchroniser and tick-rate edge history
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_serial};
            if (clk_en) rx_prev <= rx_s;
        end
    end

    // RX state register
    always_ff @(posedge CLK) begin
        if (RST) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX next state: half-bit start validation, then centre sampling
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:   if (clk_en && rx_prev && !rx_s) rx_next = RX_START;
            RX_START:  if (rx_sample) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_idx == rx_nbits - 1'b1)
                           rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (clk_en && rx_s) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: byte push at a good stop bit and error set pulses
    always_comb begin
        rx_word    = rx_shift >> (4'(DATA_BITS) - rx_nbits);
        rx_push    = (rx_state == RX_STOP) && rx_sample && rx_s;
        rx_push_ok = rx_push && (!rx_full || rx_pop);
        err_set[0] = (rx_state == RX_PARITY) && rx_sample && (rx_s != (rx_par_acc ^ rx_par_odd));
        err_set[1] = (rx_state == RX_STOP) && rx_sample && !rx_s;
        err_set[2] = rx_push && rx_full && !rx_pop;
    end

    // RX datapath: per-frame config latch, bit timer, LSB-first shifter, parity
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_div     <= '0;
            rx_cnt     <= '0;
            rx_nbits   <= '0;
            rx_bit_idx <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_acc <= 1'b0;
            rx_shift   <= '0;
        end else if (rx_state == RX_IDLE && rx_next == RX_START) begin
            rx_div     <= baud_div;
            rx_nbits   <= frame_bits(data_len);
            rx_par_en  <= parity_en;
            rx_par_odd <= parity_odd;
            rx_par_acc <= 1'b0;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else if (clk_en && rx_state != RX_IDLE && rx_state != RX_BREAK) begin
            if (rx_sample) begin
                rx_cnt <= '0;
                if (rx_state == RX_DATA) begin
                    rx_shift   <= {rx_s, rx_shift[DATA_BITS-1:1]};
                    rx_bit_idx <= rx_bit_idx + 1'b1;
                    rx_par_acc <= rx_par_acc ^ rx_s;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags; a set in the clearing cycle survives
    always_ff @(posedge CLK) begin
        if (RST) err_flags <= '0;
        else     err_flags <= (err_clr ? 3'b000 : err_flags) | err_set;
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: loopback, parity, framing, overrun,
// TX FIFO fill, glitch rejection and reset abort, with an RX byte scoreboard.
module tb_uart_fifo_core;
    localparam int DATA_BITS   = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int DIV_W       = 16;
    localparam int SYNC_STAGES = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             clk_en = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd16;
    logic [1:0]       data_len = 2'd3;
    logic             parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
    logic             rx_serial, tx_serial;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_wr = 1'b0, tx_full, tx_busy;
    logic [7:0]       rx_data;
    logic             rx_rd = 1'b0, rx_empty;
    logic [4:0]       rx_level;
    logic [2:0]       err_flags;
    logic             err_clr = 1'b0;

    logic loopback = 1'b0;
    logic rx_drive = 1'b1;
    assign rx_serial = loopback ? tx_serial : rx_drive;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cur_div = 16;
    logic [7:0] sb[$];

    uart_fifo_core #(
        .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK(CLK), .RST(RST), .clk_en(clk_en), .baud_div(baud_div), .data_len(data_len),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .rx_serial(rx_serial), .tx_serial(tx_serial), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx_busy(tx_busy), .rx_data(rx_data), .rx_rd(rx_rd),
        .rx_empty(rx_empty), .rx_level(rx_level), .err_flags(err_flags), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_cfg(input int div, input logic [1:0] len, input logic pe, input logic po, input logic ts);
        cur_div = div; baud_div = DIV_W'(div); data_len = len;
        parity_en = pe; parity_odd = po; two_stop = ts;
    endtask

    task automatic drive_bit(input logic b);
        rx_drive = b;
        cycles(cur_div);
    endtask

    // Drives one frame on rx_serial; the line is left at the stop value plus idle_bits of high
    task automatic send_rx_frame(input logic [7:0] d, input int nbits, input logic pe, input logic po,
                                 input logic bad_par, input logic stop_val, input int idle_bits);
        logic p;
        p = po;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(d[i]);
            p = p ^ d[i];
        end
        if (pe) drive_bit(p ^ bad_par);
        drive_bit(stop_val);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data = d; tx_wr = 1'b1;
        @(negedge CLK);
        tx_wr = 1'b0;
    endtask

    task automatic pulse_err_clr;
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
    endtask

    task automatic wait_rx(output bit ok);
        int t;
        t = 0;
        while (rx_empty && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        ok = !rx_empty;
    endtask

    task automatic pop_rx(output logic [7:0] d, output bit ok);
        wait_rx(ok);
        d = rx_data;
        if (ok) begin
            rx_rd = 1'b1;
            @(negedge CLK);
            rx_rd = 1'b0;
        end
    endtask

    task automatic wait_tx_start(output bit ok);
        int t;
        t = 0;
        while (tx_serial && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        ok = !tx_serial;
    endtask

    // Called at the first sample after the start-bit entry edge; returns at the next frame slot
    task automatic capture_tx(input int nbits, input logic pe, input int nstop,
                              output logic at_edge, output logic [7:0] data,
                              output logic pbit, output logic [1:0] stops);
        at_edge = tx_serial;
        cycles(cur_div / 2);
        data = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            cycles(cur_div);
            data[i] = tx_serial;
        end
        pbit = 1'b0;
        if (pe) begin
            cycles(cur_div);
            pbit = tx_serial;
        end
        stops = 2'b00;
        for (int s = 0; s < nstop; s++) begin
            cycles(cur_div);
            stops[s] = tx_serial;
        end
        cycles(cur_div - cur_div / 2);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cycles(5);
        n_cmp++; if (tx_serial !== 1'b1) begin n_err++; $display("FAIL reset_tx_serial: got %b want 1", tx_serial); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        n_cmp++; if (tx_full !== 1'b0) begin n_err++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
        n_cmp++; if (rx_level !== 5'd0) begin n_err++; $display("FAIL reset_rx_level: got %0d want 0", rx_level); end
        n_cmp++; if (err_flags !== 3'b000) begin n_err++; $display("FAIL reset_err_flags: got %b want 000", err_flags); end
        RST = 1'b0;
        cycles(2);
    endtask

    task automatic test_loopback;
        int n;
        bit ok;
        logic [7:0] d, e;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        loopback = 1'b1;
        sb.push_back(8'hA5);
        write_tx(8'hA5);
        n_cmp++; if (tx_serial !== 1'b1) begin n_err++; $display("FAIL lb_first_edge: got %b want 1", tx_serial); end
        @(negedge CLK);
        n_cmp++; if (tx_serial !== 1'b0) begin n_err++; $display("FAIL lb_start_latency: got %b want 0", tx_serial); end
        n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++; if (n != 160) begin n_err++; $display("FAIL lb_frame_ticks: got %0d want 160", n); end
        wait_rx(ok);
        n_cmp++; if (rx_level !== 5'd1) begin n_err++; $display("FAIL lb_rx_level: got %0d want 1", rx_level); end
        pop_rx(d, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL lb_rx_data: got %h (ok=%0d) want %h", d, ok, e); end
        loopback = 1'b0;
        cycles(4);
    endtask

    task automatic test_parity;
        bit ok;
        logic at_edge, pbit;
        logic [7:0] d, e;
        logic [1:0] stops;
        set_cfg(16, 2'd3, 1'b1, 1'b0, 1'b0);
        write_tx(8'h07);
        wait_tx_start(ok);
        capture_tx(8, 1'b1, 1, at_edge, d, pbit, stops);
        n_cmp++; if (!ok || d !== 8'h07) begin n_err++; $display("FAIL par_tx_data: got %h want 07", d); end
        n_cmp++; if (pbit !== 1'b1) begin n_err++; $display("FAIL par_tx_bit: got %b want 1", pbit); end
        n_cmp++; if (stops[0] !== 1'b1) begin n_err++; $display("FAIL par_tx_stop: got %b want 1", stops[0]); end
        sb.push_back(8'h5A);
        send_rx_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        pop_rx(d, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL par_good_data: got %h want %h", d, e); end
        n_cmp++; if (err_flags !== 3'b000) begin n_err++; $display("FAIL par_good_flags: got %b want 000", err_flags); end
        sb.push_back(8'h3C);
        send_rx_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        wait_rx(ok);
        n_cmp++; if (err_flags !== 3'b001) begin n_err++; $display("FAIL par_bad_flags: got %b want 001", err_flags); end
        pop_rx(d, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL par_bad_data: got %h want %h", d, e); end
        pulse_err_clr();
        n_cmp++; if (err_flags !== 3'b000) begin n_err++; $display("FAIL par_clear: got %b want 000", err_flags); end
    endtask

    task automatic test_frame_err;
        bit ok;
        logic [7:0] d, e;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        send_rx_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cycles(40);
        rx_drive = 1'b1;
        cycles(2 * cur_div);
        n_cmp++; if (err_flags !== 3'b010) begin n_err++; $display("FAIL frm_flags: got %b want 010", err_flags); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL frm_rx_empty: got %b want 1", rx_empty); end
        sb.push_back(8'h3E);
        send_rx_frame(8'h3E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        pop_rx(d, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL frm_recover: got %h want %h", d, e); end
        pulse_err_clr();
    endtask

    task automatic test_overrun;
        bit ok;
        logic [7:0] b, d, e;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 37 + 11);
            if (i < 16) sb.push_back(b);
            send_rx_frame(b, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        end
        n_cmp++; if (rx_level !== 5'd16) begin n_err++; $display("FAIL ovr_level: got %0d want 16", rx_level); end
        n_cmp++; if (err_flags !== 3'b100) begin n_err++; $display("FAIL ovr_flags: got %b want 100", err_flags); end
        n_cmp++; if (rx_data !== sb[0]) begin n_err++; $display("FAIL ovr_head: got %h want %h", rx_data, sb[0]); end
        pulse_err_clr();
        n_cmp++; if (err_flags !== 3'b000) begin n_err++; $display("FAIL ovr_clear: got %b want 000", err_flags); end
        for (int i = 0; i < 16; i++) begin
            pop_rx(d, ok);
            e = sb.pop_front();
            n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL ovr_drain[%0d]: got %h want %h", i, d, e); end
        end
        rx_rd = 1'b1;
        @(negedge CLK);
        rx_rd = 1'b0;
        n_cmp++; if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin
            n_err++; $display("FAIL rd_when_empty: got level %0d empty %b want 0/1", rx_level, rx_empty);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic at_edge, pbit;
        logic [7:0] d, b;
        logic [1:0] stops;
        logic [7:0] txq[$];
        clk_en = 1'b0;
        set_cfg(8, 2'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 29 + 3);
            if (i < 16) txq.push_back(b);
            write_tx(b);
            if (i == 14) begin
                n_cmp++; if (tx_full !== 1'b0) begin n_err++; $display("FAIL b2b_not_full_15: got %b want 0", tx_full); end
            end
            if (i == 15) begin
                n_cmp++; if (tx_full !== 1'b1) begin n_err++; $display("FAIL b2b_full_16: got %b want 1", tx_full); end
            end
        end
        n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_frozen: got %b want 1", tx_busy); end
        clk_en = 1'b1;
        wait_tx_start(ok);
        for (int f = 0; f < 16; f++) begin
            b = txq.pop_front();
            capture_tx(5, 1'b1, 2, at_edge, d, pbit, stops);
            n_cmp++; if (!ok || at_edge !== 1'b0) begin n_err++; $display("FAIL b2b_start[%0d]: got %b want 0", f, at_edge); end
            n_cmp++; if (d !== {3'b000, b[4:0]}) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", f, d, {3'b000, b[4:0]}); end
            n_cmp++; if (pbit !== ~^b[4:0]) begin n_err++; $display("FAIL b2b_parity[%0d]: got %b want %b", f, pbit, ~^b[4:0]); end
            n_cmp++; if (stops !== 2'b11) begin n_err++; $display("FAIL b2b_stops[%0d]: got %b want 11", f, stops); end
        end
        n_cmp++; if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            n_err++; $display("FAIL b2b_17th_dropped: got busy %b line %b want 0/1", tx_busy, tx_serial);
        end
    endtask

    task automatic test_glitch_and_reset;
        bit ok;
        logic [7:0] d, e;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        rx_drive = 1'b0;
        cycles(3);
        rx_drive = 1'b1;
        cycles(40);
        n_cmp++; if (rx_empty !== 1'b1 || err_flags !== 3'b000) begin
            n_err++; $display("FAIL glitch_reject: got empty %b flags %b want 1/000", rx_empty, err_flags);
        end
        sb.push_back(8'hC3);
        send_rx_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        pop_rx(d, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e) begin n_err++; $display("FAIL glitch_recover: got %h want %h", d, e); end
        write_tx(8'h00);
        wait_tx_start(ok);
        cycles(40);
        n_cmp++; if (!ok || tx_serial !== 1'b0) begin n_err++; $display("FAIL rst_mid_frame_line: got %b want 0", tx_serial); end
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++; if (tx_serial !== 1'b1) begin n_err++; $display("FAIL rst_abort_line: got %b want 1", tx_serial); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_abort_busy: got %b want 0", tx_busy); end
        RST = 1'b0;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_glitch_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
